// File: rtl/matrix_multiplier_seq_if.sv
// Bus bundle for matrix_multiplier_seq: start request, operand matrices, status and result.
// The o_sat member exists only when MATMUL_SAT_EN is defined.
interface matrix_multiplier_seq_if #(
   parameter int M          = 4,
   parameter int N          = 3,
   parameter int O          = 2,
   parameter int DATA_WIDTH = 16
);
   logic                       i_start;
   logic [M*N*DATA_WIDTH-1:0]  i_x1;
   logic [N*O*DATA_WIDTH-1:0]  i_x2;
   logic                       o_ready;
   logic                       o_busy;
   logic                       o_done;
   logic [M*O*DATA_WIDTH-1:0]  o_y;
   logic [1:0]                 o_state;
`ifdef MATMUL_SAT_EN
   logic                       o_sat;

   modport master (output i_start, i_x1, i_x2,
                   input  o_ready, o_busy, o_done, o_y, o_state, o_sat);
   modport slave  (input  i_start, i_x1, i_x2,
                   output o_ready, o_busy, o_done, o_y, o_state, o_sat);
`else
   modport master (output i_start, i_x1, i_x2,
                   input  o_ready, o_busy, o_done, o_y, o_state);
   modport slave  (input  i_start, i_x1, i_x2,
                   output o_ready, o_busy, o_done, o_y, o_state);
`endif
endinterface

// File: rtl/matrix_multiplier_seq.sv
// Sequential signed matrix multiplier Y = X1 (MxN) * X2 (NxO), O MAC lanes, M*N RUN cycles per job.
// Define MATMUL_SAT_EN to saturate the output reduction and drive the sticky-per-job o_sat flag.
module matrix_multiplier_seq #(
   parameter int M          = 4,
   parameter int N          = 3,
   parameter int O          = 2,
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 0,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N) + 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   matrix_multiplier_seq_if.slave  bus
);
   localparam int W  = DATA_WIDTH;
   localparam int IW = (M > 1) ? $clog2(M) : 1;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(M-1);
   localparam logic [KW-1:0] K_LAST = KW'(N-1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_accept;
   logic   w_row_end;
   logic   w_last;

   logic [M*N*W-1:0]            r_x1;
   logic [N*O*W-1:0]            r_x2;
   logic [IW-1:0]               r_i;
   logic [KW-1:0]               r_k;
   logic signed [ACC_WIDTH-1:0] r_acc [O];
   logic signed [W-1:0]         r_buf [M][O];
   logic [M*O*W-1:0]            r_y;

   logic signed [W-1:0]         w_a_sel;
   logic signed [W-1:0]         w_b_sel [O];
   logic signed [2*W-1:0]       w_prod  [O];
   logic signed [ACC_WIDTH-1:0] w_sum   [O];
   logic signed [W-1:0]         w_row   [O];
   logic [M*O*W-1:0]            w_y_nxt;
`ifdef MATMUL_SAT_EN
   logic [O-1:0]                w_lane_sat;
   logic                        w_row_sat;
   logic                        r_sat_job;
   logic                        r_sat;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_row_end   = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (r_k == K_LAST) begin
               w_row_end = 1'b1;
               if (r_i == I_LAST) begin
                  w_last      = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand fetch from the latched matrices, element (i,k) of X1 and row k of X2.
   always_comb begin
      w_a_sel = '0;
      for (int i = 0; i < M; i++)
         for (int k = 0; k < N; k++)
            if (r_i == IW'(i) && r_k == KW'(k)) w_a_sel = r_x1[M*N*W-(i*N+k)*W-1 -: W];
   end

   always_comb begin
      for (int j = 0; j < O; j++) begin
         w_b_sel[j] = '0;
         for (int k = 0; k < N; k++)
            if (r_k == KW'(k)) w_b_sel[j] = r_x2[N*O*W-(k*O+j)*W-1 -: W];
      end
   end

   for (genvar gj = 0; gj < O; gj++) begin : g_lane
      // Low 2W bits of the sign-extended product equal the exact signed product.
      assign w_prod[gj] = {{W{w_a_sel[W-1]}}, w_a_sel} * {{W{w_b_sel[gj][W-1]}}, w_b_sel[gj]};
      assign w_sum[gj]  = r_acc[gj] + {{(ACC_WIDTH-2*W){w_prod[gj][2*W-1]}}, w_prod[gj]};
`ifdef MATMUL_SAT_EN
      logic signed [ACC_WIDTH-1:0] w_sh;
      assign w_sh = w_sum[gj] >>> FRAC_BITS;
      assign w_lane_sat[gj] = ~((&w_sh[ACC_WIDTH-1:W-1]) | ~(|w_sh[ACC_WIDTH-1:W-1]));
      assign w_row[gj] = !w_lane_sat[gj]     ? w_sh[W-1:0] :
                         w_sh[ACC_WIDTH-1]   ? {1'b1, {(W-1){1'b0}}} :
                                               {1'b0, {(W-1){1'b1}}};
`else
      assign w_row[gj] = W'(w_sum[gj] >>> FRAC_BITS);
`endif
   end

`ifdef MATMUL_SAT_EN
   assign w_row_sat = |w_lane_sat;
`endif

   // The last row is still in flight at the edge that loads y, so bypass it.
   for (genvar gi = 0; gi < M; gi++) begin : g_y_row
      for (genvar gj = 0; gj < O; gj++) begin : g_y_col
         assign w_y_nxt[M*O*W-(gi*O+gj)*W-1 -: W] = (r_i == IW'(gi)) ? w_row[gj] : r_buf[gi][gj];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_x1 <= '0;
         r_x2 <= '0;
         r_i  <= '0;
         r_k  <= '0;
         r_y  <= '0;
         for (int j = 0; j < O; j++) r_acc[j] <= '0;
         for (int i = 0; i < M; i++)
            for (int j = 0; j < O; j++) r_buf[i][j] <= '0;
`ifdef MATMUL_SAT_EN
         r_sat_job <= 1'b0;
         r_sat     <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_x1 <= bus.i_x1;
            r_x2 <= bus.i_x2;
            r_i  <= '0;
            r_k  <= '0;
            for (int j = 0; j < O; j++) r_acc[j] <= '0;
`ifdef MATMUL_SAT_EN
            r_sat_job <= 1'b0;
`endif
         end else if (r_state == S_RUN) begin
            if (w_row_end) begin
               r_k <= '0;
               r_i <= w_last ? '0 : r_i + IW'(1);
               for (int j = 0; j < O; j++) r_acc[j] <= '0;
               for (int i = 0; i < M; i++)
                  for (int j = 0; j < O; j++)
                     if (r_i == IW'(i)) r_buf[i][j] <= w_row[j];
`ifdef MATMUL_SAT_EN
               r_sat_job <= r_sat_job | w_row_sat;
`endif
            end else begin
               r_k <= r_k + KW'(1);
               for (int j = 0; j < O; j++) r_acc[j] <= w_sum[j];
            end
         end
         if (w_last) begin
            r_y <= w_y_nxt;
`ifdef MATMUL_SAT_EN
            r_sat <= r_sat_job | w_row_sat;
`endif
         end
      end
   end

   assign bus.o_ready = (r_state == S_IDLE);
   assign bus.o_busy  = (r_state == S_RUN) || (r_state == S_DONE);
   assign bus.o_done  = (r_state == S_DONE);
   assign bus.o_y     = r_y;
   assign bus.o_state = r_state;
`ifdef MATMUL_SAT_EN
   assign bus.o_sat   = r_sat;
`endif
endmodule
